// File: rtl/gc_dram_host_port.sv
// Host-side GC-DRAM initiator: queues host requests, issues them in order around refresh, and
// returns read data in order. Define HOST_STALL_CNT_EN to add the stall_cnt output.
module gc_dram_host_port #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_rd
`ifdef HOST_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StStall} state_t;

    state_t state;

    logic [QDEPTH-1:0] q_wr;
    logic [ADDR_W-1:0] q_addr  [QDEPTH];
    logic [DATA_W-1:0] q_wdata [QDEPTH];
    logic [PW-1:0]     q_wptr, q_rptr;
    logic [CW-1:0]     q_count, q_count_next;

    logic [DATA_W-1:0] r_data [QDEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;

    logic [RD_LAT-1:0] rd_pipe;
    logic [CW-1:0]     inflight;

    logic q_empty, push_req, credit, head_wr, issue, issue_wr, issue_rd, capture, pop_rsp;

    // The FSM is the authority on whether the request FIFO holds anything.
    assign q_empty  = (state == StIdle);
    assign req_ready = (q_count != CW'(QDEPTH));
    assign push_req = req_valid & req_ready;
    assign credit   = ({1'b0, inflight} + {1'b0, r_count}) < (CW + 1)'(QDEPTH);
    assign head_wr  = q_wr[q_rptr];
    assign issue    = !q_empty && !mem_busy && (head_wr || credit);
    assign issue_wr = issue & head_wr;
    assign issue_rd = issue & !head_wr;
    assign capture  = rd_pipe[RD_LAT-1];
    assign rsp_valid = (r_count != '0);
    assign pop_rsp  = rsp_valid & rsp_ready;
    assign q_count_next = q_count + CW'(push_req) - CW'(issue);

    always_comb begin
        mem_we    = issue_wr;
        mem_re    = issue_rd;
        mem_waddr = issue_wr ? q_addr[q_rptr] : '0;
        mem_raddr = issue_rd ? q_addr[q_rptr] : '0;
        mem_in    = issue_wr ? q_wdata[q_rptr] : '0;
        rsp_rdata = rsp_valid ? r_data[r_rptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (push_req) begin
            q_wr[q_wptr]    <= req_wr;
            q_addr[q_wptr]  <= req_addr;
            q_wdata[q_wptr] <= req_wdata;
        end
        if (capture) begin
            r_data[r_wptr] <= mem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wptr  <= '0;
            q_rptr  <= '0;
            q_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_req) q_wptr <= q_wptr + 1'b1;
            if (issue)    q_rptr <= q_rptr + 1'b1;
            q_count <= q_count_next;
            if (capture)  r_wptr <= r_wptr + 1'b1;
            if (pop_rsp)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(capture) - CW'(pop_rsp);
        end
    end

    // Dropping the pipe on reset discards data of reads already on the DRAM bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe  <= '0;
            inflight <= '0;
        end else begin
            rd_pipe[0] <= issue_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            inflight <= inflight + CW'(issue_rd) - CW'(capture);
        end
    end

    // Stall means a head was present but blocked in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else if (q_count_next == '0) begin
            state <= StIdle;
        end else if (!q_empty && !issue) begin
            state <= StStall;
        end else begin
            state <= StIssue;
        end
    end

`ifdef HOST_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == StStall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
